// File: rtl/hcsr04_emulador.sv
// Synthesizable HC-SR04 stand-in: validates the trigger width, waits out the burst delay,
// then answers with an echo pulse sized from the programmed distance.
module hcsr04_emulador #(
  parameter int TRIG_MIN_CICLOS     = 500,
  parameter int ATRASO_CICLOS       = 10000,
  parameter int CICLOS_POR_CM       = 2941,
  parameter int DIST_MIN            = 2,
  parameter int DIST_MAX            = 400,
  parameter int ECHO_TIMEOUT_CICLOS = 1900000,
  parameter int HOLDOFF_CICLOS      = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trigger,
  input  logic [11:0] distancia,
  input  logic        sem_objeto,
  output logic        echo,
  output logic        ocupado,
  output logic        erro_trigger,
  output logic [3:0]  db_estado
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CICLOS = max2(max2(max2(TRIG_MIN_CICLOS, ATRASO_CICLOS),
                                        max2(CICLOS_POR_CM, ECHO_TIMEOUT_CICLOS)),
                                   HOLDOFF_CICLOS);
  localparam int CNT_W = $clog2(MAX_CICLOS + 1);

  localparam logic [CNT_W-1:0] TRIG_LIM    = CNT_W'(TRIG_MIN_CICLOS);
  localparam logic [CNT_W-1:0] ATRASO_FIM  = CNT_W'(ATRASO_CICLOS - 1);
  localparam logic [CNT_W-1:0] CM_FIM      = CNT_W'(CICLOS_POR_CM - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_FIM = CNT_W'(ECHO_TIMEOUT_CICLOS - 1);
  localparam logic [CNT_W-1:0] HOLD_FIM    = CNT_W'(HOLDOFF_CICLOS - 1);
  localparam logic [CNT_W-1:0] CNT_UM      = CNT_W'(1);
  localparam logic [11:0]      DIST_MIN_V  = 12'(DIST_MIN);
  localparam logic [11:0]      DIST_MAX_V  = 12'(DIST_MAX);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    ESPERA    = 4'd1,
    MEDE_TRIG = 4'd2,
    ATRASO    = 4'd3,
    ECHO      = 4'd4,
    HOLDOFF   = 4'd5
  } estado_t;

  estado_t          state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [11:0]      cm_reg, cm_next;
  logic             timeout_reg, timeout_next;
  logic             echo_reg, echo_next;
  logic             erro_reg, erro_next;
  logic             trig_m_reg, trig_s_reg, trig_d_reg;
  logic             sobe, desce;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trig_m_reg <= 1'b0;
      trig_s_reg <= 1'b0;
      trig_d_reg <= 1'b0;
    end else begin
      trig_m_reg <= trigger;
      trig_s_reg <= trig_m_reg;
      trig_d_reg <= trig_s_reg;
    end
  end

  assign sobe  = trig_s_reg & ~trig_d_reg;
  assign desce = ~trig_s_reg & trig_d_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= INICIAL;
      cnt_reg     <= '0;
      cm_reg      <= '0;
      timeout_reg <= 1'b0;
      echo_reg    <= 1'b0;
      erro_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cm_reg      <= cm_next;
      timeout_reg <= timeout_next;
      echo_reg    <= echo_next;
      erro_reg    <= erro_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cm_next      = cm_reg;
    timeout_next = timeout_reg;
    erro_next    = 1'b0;
    echo_next    = (state_reg == ECHO);
    case (state_reg)
      INICIAL: state_next = ESPERA;
      ESPERA: begin
        if (sobe) begin
          // The edge-detect cycle already saw trig_s high, so it counts as the first cycle.
          cnt_next   = CNT_UM;
          state_next = MEDE_TRIG;
        end
      end
      MEDE_TRIG: begin
        if (desce) begin
          if (cnt_reg >= TRIG_LIM) begin
            timeout_next = sem_objeto | (distancia > DIST_MAX_V);
            cm_next      = (distancia < DIST_MIN_V) ? DIST_MIN_V : distancia;
            cnt_next     = '0;
            state_next   = ATRASO;
          end else begin
            erro_next  = 1'b1;
            state_next = ESPERA;
          end
        end else if (cnt_reg < TRIG_LIM) begin
          cnt_next = cnt_reg + CNT_UM;
        end
      end
      ATRASO: begin
        if (cnt_reg == ATRASO_FIM) begin
          cnt_next   = '0;
          state_next = ECHO;
        end else begin
          cnt_next = cnt_reg + CNT_UM;
        end
      end
      ECHO: begin
        if (timeout_reg) begin
          if (cnt_reg == TIMEOUT_FIM) begin
            cnt_next   = '0;
            state_next = HOLDOFF;
          end else begin
            cnt_next = cnt_reg + CNT_UM;
          end
        end else if (cnt_reg == CM_FIM) begin
          // Inner counter spans one centimetre; cm_reg counts remaining centimetres.
          cnt_next = '0;
          if (cm_reg <= 12'd1) state_next = HOLDOFF;
          else                 cm_next    = cm_reg - 12'd1;
        end else begin
          cnt_next = cnt_reg + CNT_UM;
        end
      end
      HOLDOFF: begin
        if (cnt_reg == HOLD_FIM) begin
          cnt_next   = '0;
          state_next = ESPERA;
        end else begin
          cnt_next = cnt_reg + CNT_UM;
        end
      end
      default: state_next = INICIAL;
    endcase
  end

  assign echo         = echo_reg;
  assign erro_trigger = erro_reg;
  assign ocupado      = (state_reg == ATRASO) | (state_reg == ECHO) | (state_reg == HOLDOFF);
  assign db_estado    = state_reg;

endmodule

// File: tb/tb_hcsr04_emulador.sv
// Directed bench for hcsr04_emulador: expected echo pulses are queued when a trigger is
// driven and matched by a monitor that measures each echo's rise cycle and width.
module tb_hcsr04_emulador;

  localparam int TRIG = 10;
  localparam int A    = 20;
  localparam int CPC  = 5;
  localparam int DMIN = 2;
  localparam int DMAX = 400;
  localparam int TO   = 3000;
  localparam int H    = 50;

  logic        clock;
  logic        reset;
  logic        trigger;
  logic [11:0] distancia;
  logic        sem_objeto;
  logic        echo;
  logic        ocupado;
  logic        erro_trigger;
  logic [3:0]  db_estado;

  hcsr04_emulador #(
    .TRIG_MIN_CICLOS(TRIG), .ATRASO_CICLOS(A), .CICLOS_POR_CM(CPC),
    .DIST_MIN(DMIN), .DIST_MAX(DMAX), .ECHO_TIMEOUT_CICLOS(TO), .HOLDOFF_CICLOS(H)
  ) dut (
    .clock(clock), .reset(reset), .trigger(trigger), .distancia(distancia),
    .sem_objeto(sem_objeto), .echo(echo), .ocupado(ocupado),
    .erro_trigger(erro_trigger), .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int rise;
    int width;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   checks = 0;
  int   errors = 0;
  logic echo_prev = 1'b0;
  int   rise_cyc = 0;

  // Echo monitor: rise cycle checked against the queue head, width checked on the fall.
  always @(negedge clock) begin
    if (echo === 1'b1 && echo_prev !== 1'b1) begin
      rise_cyc = cyc;
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL echo_unexpected got rise at %0d exp no echo", cyc);
      end
      if (sb.size() != 0) begin
        checks++;
        assert (cyc === sb[0].rise)
        else begin
          errors++;
          $error("FAIL echo_rise got %0d exp %0d", cyc, sb[0].rise);
        end
      end
    end else if (echo !== 1'b1 && echo_prev === 1'b1) begin
      if (sb.size() != 0) begin
        e_mon = sb.pop_front();
        checks++;
        assert ((cyc - rise_cyc) === e_mon.width)
        else begin
          errors++;
          $error("FAIL echo_width got %0d exp %0d", cyc - rise_cyc, e_mon.width);
        end
        $display("echo pulse rise=%0d width=%0d expected_width=%0d", rise_cyc, cyc - rise_cyc, e_mon.width);
      end
    end
    echo_prev = echo;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Drives a trigger of n cycles; optionally queues the echo it must produce.
  task automatic pulse(input int n, input int d, input logic so, input bit push, input int w);
    exp_t e;
    distancia  = 12'(d);
    sem_objeto = so;
    @(negedge clock);
    trigger = 1'b1;
    repeat (n) @(negedge clock);
    trigger = 1'b0;
    if (push) begin
      e.rise  = cyc + 1 + 3 + A;
      e.width = w;
      sb.push_back(e);
    end
    $display("trigger width=%0d distancia=%0d sem_objeto=%0d fall_cycle=%0d", n, d, so, cyc + 1);
  endtask

  task automatic wait_busy(output int t);
    for (int i = 0; i < 100 && ocupado !== 1'b1; i++) @(negedge clock);
    t = (ocupado === 1'b1) ? cyc : -1;
  endtask

  task automatic wait_free(output int t);
    int tb;
    wait_busy(tb);
    for (int i = 0; i < 5000 && ocupado !== 1'b0; i++) @(negedge clock);
    t = (ocupado === 1'b0) ? cyc : -1;
    chk("ocupado_bound", {31'd0, ocupado}, 32'd0);
  endtask

  int p, t, n;

  initial begin
    reset      = 1'b0;
    trigger    = 1'b0;
    distancia  = '0;
    sem_objeto = 1'b0;
    #1;
    chk("reset_echo", {31'd0, echo}, 32'd0);
    chk("reset_ocupado", {31'd0, ocupado}, 32'd0);
    chk("reset_erro", {31'd0, erro_trigger}, 32'd0);
    chk("reset_estado", {28'd0, db_estado}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("estado_espera", {28'd0, db_estado}, 32'd1);

    // Nominal measurement
    pulse(12, 25, 1'b0, 1'b1, 125);
    p = cyc;
    wait_busy(t);
    chk("ocupado_sobe", t, p + 3);
    chk("estado_atraso", {28'd0, db_estado}, 32'd3);
    wait_free(t);
    chk("ocupado_desce", t, p + 3 + A + 125 + H);
    chk("estado_fim", {28'd0, db_estado}, 32'd1);

    // Short trigger
    pulse(6, 25, 1'b0, 1'b0, 0);
    n = 0;
    repeat (10) begin
      @(negedge clock);
      if (erro_trigger === 1'b1) n++;
    end
    chk("erro_pulso", n, 1);
    chk("estado_curto", {28'd0, db_estado}, 32'd1);
    chk("ocupado_curto", {31'd0, ocupado}, 32'd0);

    // Clamp and timeout
    pulse(12, 0, 1'b0, 1'b1, DMIN * CPC);
    wait_free(t);
    pulse(12, 401, 1'b0, 1'b1, TO);
    wait_free(t);
    pulse(12, 30, 1'b1, 1'b1, TO);
    wait_free(t);

    // Triggers during ECHO and HOLDOFF are ignored
    pulse(12, 25, 1'b0, 1'b1, 125);
    p = cyc;
    repeat (40) @(negedge clock);
    pulse(12, 25, 1'b0, 1'b0, 0);
    while (cyc < p + 155) @(negedge clock);
    pulse(12, 25, 1'b0, 1'b0, 0);
    wait_free(t);
    chk("holdoff_fixo", t, p + 3 + A + 125 + H);
    pulse(12, 25, 1'b0, 1'b1, 125);
    wait_free(t);

    // Distance latched at the trigger fall
    pulse(12, 10, 1'b0, 1'b1, 50);
    repeat (5) @(negedge clock);
    distancia = 12'd300;
    wait_free(t);

    // Reset 40 cycles into the echo cuts it immediately
    pulse(12, 30, 1'b0, 1'b1, 41);
    for (int i = 0; i < 100 && echo !== 1'b1; i++) @(negedge clock);
    repeat (40) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("reset_meio_echo", {31'd0, echo}, 32'd0);
    chk("reset_meio_estado", {28'd0, db_estado}, 32'd0);
    chk("reset_meio_ocupado", {31'd0, ocupado}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("estado_pos_reset", {28'd0, db_estado}, 32'd1);
    pulse(12, 4, 1'b0, 1'b1, 20);
    wait_free(t);

    repeat (5) @(negedge clock);
    chk("fila_vazia", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
